alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_rr_arbiter.sv | 117 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between the CPU, multiply FSM and divide FSM.
// Registered one-hot grant, lock with hold-limit preemption, and 1-cycle result capture.
module alu_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [5:0]  op0,
  input  logic [5:0]  op1,
  input  logic [5:0]  op2,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] y0,
  input  logic [15:0] y1,
  input  logic [15:0] y2,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic [5:0]  alu_opcode,
  output logic [15:0] alu_x_in,
  output logic [15:0] alu_y_in,
  output logic [2:0]  gnt,
  output logic [15:0] res_data,
  output logic [3:0]  res_flags,
  output logic [2:0]  res_valid,
  output logic [2:0]  preempt,
  output logic        busy
);

  localparam int CW = (MAX_HOLD > 15) ? $clog2(MAX_HOLD + 1) : 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    last_winner;
  logic [CW-1:0] hold_cnt;    // completed cycles of the current grant before this one

  logic [1:0] p0, p1, p2;
  logic [1:0] win_idx;
  logic       hold_hit;
  logic       keep;

  // The limit is reached in the MAX_HOLD-th consecutive grant cycle.
  assign hold_hit = (hold_cnt >= CW'(MAX_HOLD - 1));
  assign keep     = (state == GRANT) && (|(gnt & req & lock)) && !(hold_hit && |(req & ~gnt));
  assign busy     = |gnt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_winner)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase

    if (req[p0])      win_idx = p0;
    else if (req[p1]) win_idx = p1;
    else              win_idx = p2;
  end

  always_comb begin
    alu_opcode = '0;
    alu_x_in   = '0;
    alu_y_in   = '0;
    case (gnt)
      3'b001: begin alu_opcode = op0; alu_x_in = x0; alu_y_in = y0; end
      3'b010: begin alu_opcode = op1; alu_x_in = x1; alu_y_in = y1; end
      3'b100: begin alu_opcode = op2; alu_x_in = x2; alu_y_in = y2; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      res_valid   <= '0;
      preempt     <= '0;
      res_data    <= '0;
      res_flags   <= '0;
      hold_cnt    <= '0;
      last_winner <= 2'd2;
    end else begin
      res_valid <= gnt & req;
      if (|(gnt & req)) begin
        res_data  <= alu_result;
        res_flags <= alu_flags;
      end

      preempt <= '0;
      if (keep) begin
        if (!hold_hit)
          hold_cnt <= hold_cnt + CW'(1);
      end else begin
        // A locked, still-requesting owner only loses the grant to the hold limit.
        preempt  <= gnt & req & lock;
        hold_cnt <= '0;
        if (|req) begin
          state       <= GRANT;
          gnt         <= 3'b001 << win_idx;
          last_winner <= win_idx;
        end else begin
          state <= IDLE;
          gnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized traffic,
// all compared each cycle against an owner/queue-level behavioural model.
module tb_alu_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam logic [5:0] OP_ADD = 6'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, lock;
  logic [5:0]  op [3];
  logic [15:0] x [3];
  logic [15:0] y [3];
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_x_in, alu_y_in;
  logic [2:0]  gnt, res_valid, preempt;
  logic [15:0] res_data;
  logic [3:0]  res_flags;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: owner index (-1 = none), last winner, consecutive cycles held.
  int          m_own = -1;
  int          m_last = 2;
  int          m_cycles = 0;
  logic [2:0]  m_rv = '0;
  logic [2:0]  m_pre = '0;
  logic [15:0] m_rd = '0;
  logic [3:0]  m_rf = '0;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: {flags, result}.
  function automatic logic [19:0] alu_fn(input logic [5:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (o[1:0])
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a ^ b;
      default: r = a & b;
    endcase
    return {r == 16'd0, r[15], ^r, o[5], r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_opcode, alu_x_in, alu_y_in);

  alu_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .op0(op[0]), .op1(op[1]), .op2(op[2]),
    .x0(x[0]), .x1(x[1]), .x2(x[2]),
    .y0(y[0]), .y1(y[1]), .y2(y[2]),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_opcode(alu_opcode), .alu_x_in(alu_x_in), .alu_y_in(alu_y_in),
    .gnt(gnt), .res_data(res_data), .res_flags(res_flags),
    .res_valid(res_valid), .preempt(preempt), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [2:0]  e_gnt;
    logic [5:0]  e_op;
    logic [15:0] e_x, e_y;
    e_gnt = '0; e_op = '0; e_x = '0; e_y = '0;
    if (m_own >= 0) begin
      e_gnt = 3'b001 << m_own;
      e_op  = op[m_own];
      e_x   = x[m_own];
      e_y   = y[m_own];
    end
    check("gnt",        32'(gnt),        32'(e_gnt));
    check("busy",       32'(busy),       32'(e_gnt != 3'b000));
    check("res_valid",  32'(res_valid),  32'(m_rv));
    check("preempt",    32'(preempt),    32'(m_pre));
    check("res_data",   32'(res_data),   32'(m_rd));
    check("res_flags",  32'(res_flags),  32'(m_rf));
    check("alu_opcode", 32'(alu_opcode), 32'(e_op));
    check("alu_x_in",   32'(alu_x_in),   32'(e_x));
    check("alu_y_in",   32'(alu_y_in),   32'(e_y));
  endtask

  // Predict the post-edge state from the current inputs, clock, then compare.
  task automatic tick();
    int          n_own, n_last, n_cyc;
    logic [2:0]  n_rv, n_pre;
    logic [15:0] n_rd;
    logic [3:0]  n_rf;
    logic [19:0] a;
    logic        others, owner_locked;
    n_own = m_own; n_last = m_last; n_cyc = m_cycles;
    n_rv = '0; n_pre = '0; n_rd = m_rd; n_rf = m_rf;
    if (rst) begin
      n_own = -1; n_last = 2; n_cyc = 0; n_rd = '0; n_rf = '0;
    end else begin
      others = 1'b0;
      owner_locked = 1'b0;
      if (m_own >= 0) begin
        others = (req & ~(3'b001 << m_own)) != 3'b000;
        owner_locked = req[m_own] && lock[m_own];
        if (req[m_own]) begin
          a = alu_fn(op[m_own], x[m_own], y[m_own]);
          n_rd = a[15:0];
          n_rf = a[19:16];
          n_rv = 3'b001 << m_own;
        end
      end
      if (owner_locked && !(m_cycles >= MAX_HOLD && others)) begin
        n_cyc = m_cycles + 1;
      end else begin
        if (owner_locked) n_pre = 3'b001 << m_own;
        n_own = -1;
        for (int k = 1; k <= 3; k++) begin
          if (n_own < 0 && req[(m_last + k) % 3]) n_own = (m_last + k) % 3;
        end
        if (n_own >= 0) begin
          n_last = n_own;
          n_cyc  = 1;
        end else begin
          n_cyc = 0;
        end
      end
    end
    @(posedge clk);
    m_own = n_own; m_last = n_last; m_cycles = n_cyc;
    m_rv = n_rv; m_pre = n_pre; m_rd = n_rd; m_rf = n_rf;
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0;
    for (int i = 0; i < 3; i++) begin
      op[i] = '0; x[i] = '0; y[i] = '0;
    end
    tick();
    tick();
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_res_data", 32'(res_data), 32'd0);

    // Single CPU ADD: grant next edge, result 12 one cycle later, regrant while req holds.
    rst = 1'b0; op[0] = OP_ADD; x[0] = 16'd5; y[0] = 16'd7; req = 3'b001; lock = 3'b000;
    tick();
    check("s1_gnt", 32'(gnt), 32'b001);
    tick();
    check("s1_res_valid", 32'(res_valid), 32'b001);
    check("s1_res_data", 32'(res_data), 32'd12);
    check("s1_regrant", 32'(gnt), 32'b001);

    // All requesting, unlocked: strict rotation starting at requester 0.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111; lock = 3'b000;
    tick(); check("s2_gnt_a", 32'(gnt), 32'b001);
    tick(); check("s2_gnt_b", 32'(gnt), 32'b010); check("s2_rv_a", 32'(res_valid), 32'b001);
    tick(); check("s2_gnt_c", 32'(gnt), 32'b100); check("s2_rv_b", 32'(res_valid), 32'b010);
    tick(); check("s2_gnt_d", 32'(gnt), 32'b001); check("s2_rv_c", 32'(res_valid), 32'b100);

    // Locked requester alone holds indefinitely; a competitor triggers preemption.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b010; lock = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("s3_hold_gnt", 32'(gnt), 32'b010);
      check("s3_no_preempt", 32'(preempt), 32'd0);
    end
    req = 3'b110;
    tick();
    check("s3_switch_gnt", 32'(gnt), 32'b100);
    check("s3_preempt", 32'(preempt), 32'b010);
    tick();
    check("s3_preempt_clear", 32'(preempt), 32'd0);

    // Withdrawn request: no capture, pending requester granted immediately.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b100; lock = 3'b000;
    tick(); check("s4_gnt", 32'(gnt), 32'b100);
    req = 3'b001;
    tick();
    check("s4_no_rv", 32'(res_valid), 32'd0);
    check("s4_next_gnt", 32'(gnt), 32'b001);

    // Reset during a grant with a capture pending aborts it.
    x[1] = 16'h1234; y[1] = 16'h0101; op[1] = OP_ADD;
    req = 3'b010;
    tick(); check("s5_gnt", 32'(gnt), 32'b010);
    rst = 1'b1;
    tick();
    check("s5_rst_gnt", 32'(gnt), 32'd0);
    check("s5_rst_rv", 32'(res_valid), 32'd0);
    check("s5_rst_data", 32'(res_data), 32'd0);
    rst = 1'b0; req = 3'b111;
    tick(); check("s5_first_gnt", 32'(gnt), 32'b001);

    // Randomized traffic with sticky requests/locks and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) lock = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        op[i] = 6'($urandom);
        x[i]  = 16'($urandom);
        y[i]  = 16'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
